rom_loader: RTL and testbench
=============================

# rom_loader

Hardware program loader for the riscv_cpu_soc instruction ROM. It receives a framed byte stream from an upstream byte source (UART receiver or debug bridge) and assembles little-endian 32-bit instruction words. Each word is written into the ROM through a write port, and the CPU core is held in reset until the complete image has loaded and its checksum matches. It sits between the byte source and `rom_inst`/`riscv_cpu_inst` inside the SoC, and its status outputs replace bench-side preloading of ROM contents on silicon/FPGA builds.

## Interface
- `ROM_DEPTH`, 4096: ROM size in 32-bit words; must be a power of two.
- `ADDR_W`, $clog2(ROM_DEPTH): derived word-address width; not overridden.
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `load_req` in 1: one-cycle pulse that restarts loading from any state.
- `rx_valid` in 1: byte source has a byte on `rx_data`.
- `rx_data` in 8: stream byte.
- `rx_ready` out 1: loader accepts the byte this cycle.
- `rom_we` out 1: ROM write strobe, exactly one cycle per word.
- `rom_waddr` out ADDR_W: ROM word address.
- `rom_wdata` out 32: instruction word.
- `cpu_rst` out 1: active-low reset to the CPU core; 0 holds the CPU in reset.
- `load_done` out 1: image loaded and checksum OK.
- `load_err` out 1: length overflow or checksum mismatch.
- `word_cnt` out 16: number of words written so far.

## Operation
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4·N payload bytes, then one CHK byte.
- CHK is the sum of all payload bytes mod 256. The header bytes are not included in the sum.
- Byte transfer: a byte moves on any rising edge where `rx_valid && rx_ready`. The source may hold `rx_valid` high for any number of cycles.
- States:
  - S_LEN_LO: accept byte → S_LEN_HI.
  - S_LEN_HI: accept byte.
    - N > ROM_DEPTH → S_ERR.
    - N == 0 → S_CHK.
    - Otherwise → S_DATA.
  - S_DATA: accept payload bytes. The first byte of each group of four maps to `rom_wdata[7:0]`, the last to [31:24].
    - The 4th byte triggers a write to `rom_waddr` = word index, starting at 0.
    - After word N−1 → S_CHK.
  - S_CHK: accept byte.
    - Byte == running sum → S_DONE.
    - Otherwise → S_ERR.
  - S_DONE: `cpu_rst`=1 and `load_done`=1; `rx_ready`=0.
  - S_ERR: `load_err`=1 and `cpu_rst`=0; `rx_ready`=0.
- `rx_ready` = 1 in S_LEN_LO, S_LEN_HI, S_DATA and S_CHK. The loader never backpressures mid-frame.
- `load_req` behaviour:
  - From any state: next state S_LEN_LO; checksum, byte lane, `word_cnt` and address are cleared; `cpu_rst` driven 0; `load_done`/`load_err` cleared.
  - A byte handshaken in the same cycle as `load_req` is discarded.
- Partial words cannot be written. A frame aborted by `load_req` leaves previously written words in ROM untouched.
- Arithmetic: checksum accumulates in 8 bits and wraps. `word_cnt` is 16 bits and never exceeds N.

## Timing
- Reset values:
  - State S_LEN_LO.
  - `rom_we`=0, `rom_waddr`=0, `rom_wdata`=0.
  - `cpu_rst`=0, `load_done`=0, `load_err`=0, `word_cnt`=0.
  - `rx_ready`=1 once `rst` deasserts.
- Write latency: when the 4th byte of a word is accepted at edge k:
  - `rom_we`=1 with valid address/data during the cycle after edge k.
  - `rom_we` deasserts after one cycle.
  - `word_cnt` increments at edge k+1.
- Completion: when CHK is accepted at edge k, `load_done`/`cpu_rst` (or `load_err`) are high from edge k+1.
- The final data write (cycle k'+1) completes no later than the CHK acceptance, since CHK is accepted at earliest k'+1.
- Asserting `rst` mid-frame returns to reset values immediately (asynchronous). ROM contents are not touched.
- Maximum throughput: one byte per cycle.

## Structure
- `loader_defs` (shared include/package) holds:
  - State encodings S_LEN_LO..S_ERR.
  - Header/frame constants: `LEN_BYTES`=2, `WORD_BYTES`=4.
  - Checksum width 8.
- Sub-module `byte_packer`:
  - Shifts accepted bytes into a 32-bit register with a 2-bit lane counter.
  - Emits a one-cycle `word_valid`.
  - Has a synchronous clear driven by `load_req`.
- The top level holds the FSM, checksum, address/count registers and the ROM write-port registers.

## Test plan
- Nominal image:
  - Stimulus: N=2, bytes 13 00 00 00 13 0D 10 00, CHK=0x43, `rx_valid` held high.
  - Response: ROM[0]=0x00000013 and ROM[1]=0x00100D13, two single-cycle `rom_we` pulses; `load_done`=1 and `cpu_rst`=1 one cycle after CHK; `word_cnt`=2.
- Bad checksum:
  - Stimulus: same image with CHK=0x44.
  - Response: `load_err`=1, `cpu_rst` stays 0, `rx_ready`=0.
- Length overflow:
  - Stimulus: ROM_DEPTH=4096, N=0x1001.
  - Response: S_ERR right after LEN_HI; zero `rom_we` pulses.
- Empty image:
  - Stimulus: N=0, CHK=0x00.
  - Response: `load_done`=1, no writes.
- Gapped source:
  - Stimulus: `rx_valid` toggles every other cycle for the nominal image.
  - Response: identical ROM contents and result.
- Abort/reset:
  - Stimulus: `load_req` after 5 payload bytes, then a full nominal frame.
  - Response: only the full frame's words are written; a coincident byte is discarded.
  - Stimulus: async `rst` mid-frame.
  - Response: all outputs return to their reset values immediately.

Source files
------------

// File: rtl/loader_defs.sv
// -----------------------------------------------------------------------------
// loader_defs
//   Shared definitions for the ROM program loader:
//   - FSM state encoding (S_LEN_LO .. S_ERR)
//   - frame constants: header length, bytes per instruction word
//   - checksum and length-field widths
// -----------------------------------------------------------------------------
package loader_defs;

  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_DATA   = 3'd2,
    S_CHK    = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  localparam int LEN_BYTES  = 2;              // LEN_LO, LEN_HI
  localparam int WORD_BYTES = 4;              // bytes per instruction word
  localparam int CHK_W      = 8;              // checksum width (wraps)
  localparam int LEN_W      = 8 * LEN_BYTES;  // word-count field width
  localparam int LANE_W     = $clog2(WORD_BYTES);

endpackage

// File: rtl/byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
//   Assembles little-endian 32-bit words from a byte stream. The first byte of
//   each group lands in word_out[7:0], the fourth in word_out[31:24].
//   word_valid is combinational: it is high in the cycle the fourth byte is
//   presented, with word_out already holding the complete word, so the parent
//   can register the ROM write on that same edge.
// Ports:
//   clk, rst     - clock, asynchronous active-low reset
//   clr          - synchronous clear of lane counter and partial word
//   byte_valid   - accept byte_in this cycle
//   byte_in[7:0] - stream byte
//   word_valid   - one-cycle strobe: fourth byte of a word is being accepted
//   word_out     - assembled word (valid while word_valid)
// -----------------------------------------------------------------------------
module byte_packer
  import loader_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word_out
);

  logic [LANE_W-1:0] lane;
  logic [23:0]       partial;  // three earlier bytes, oldest in [7:0]

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of its inputs regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane    <= '0;
      partial <= '0;
    end else if (clr) begin
      lane    <= '0;
      partial <= '0;
    end else if (byte_valid) begin
      partial <= {byte_in, partial[23:8]};
      lane    <= lane + 1'b1;
    end
  end

  assign word_valid = byte_valid && !clr && (lane == LANE_W'(WORD_BYTES - 1));
  assign word_out   = {byte_in, partial};

endmodule

// File: rtl/rom_loader.sv
// -----------------------------------------------------------------------------
// rom_loader
//   Receives a framed byte stream (LEN_LO, LEN_HI, 4*N payload bytes, CHK),
//   writes each little-endian word into the instruction ROM and releases the
//   CPU reset once the whole image is in and the 8-bit payload sum matches.
// Ports:
//   clk, rst       - clock, asynchronous active-low reset
//   load_req       - one-cycle pulse: restart loading from any state
//   rx_valid/rx_data/rx_ready - byte handshake with the upstream source
//   rom_we/rom_waddr/rom_wdata - ROM write port, one-cycle strobe per word
//   cpu_rst        - active-low CPU reset (1 only after a good image)
//   load_done      - image loaded, checksum OK
//   load_err       - length overflow or checksum mismatch
//   word_cnt       - words written so far in the current frame
// -----------------------------------------------------------------------------
module rom_loader
  import loader_defs::*;
#(
  parameter int ROM_DEPTH = 4096,
  parameter int ADDR_W    = $clog2(ROM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_waddr,
  output logic [31:0]       rom_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err,
  output logic [15:0]       word_cnt
);

  localparam logic [LEN_W:0] LEN_MAX = (LEN_W + 1)'(ROM_DEPTH);

  state_t             state, state_n;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   word_idx;   // index of the next word to be written
  logic [CHK_W-1:0]   chk_q;
  logic [LEN_W-1:0]   len_rx;     // full length as LEN_HI is being accepted
  logic               byte_fire;  // byte handshake that is not discarded
  logic               data_fire;
  logic               last_word;
  logic               word_valid;
  logic [31:0]        word_out;

  assign rx_ready  = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                     (state == S_DATA)   || (state == S_CHK);
  // A byte coinciding with load_req is dropped rather than starting a frame.
  assign byte_fire = rx_valid && rx_ready && !load_req;
  assign data_fire = byte_fire && (state == S_DATA);
  assign len_rx    = {rx_data, len_q[7:0]};
  assign last_word = (word_idx == len_q - LEN_W'(1));

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (load_req),
    .byte_valid (data_fire),
    .byte_in    (rx_data),
    .word_valid (word_valid),
    .word_out   (word_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_LEN_LO;
    else      state <= state_n;
  end

  // NOTE: every variable assigned here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    if (load_req) begin
      state_n = S_LEN_LO;
    end else begin
      case (state)
        S_LEN_LO: if (byte_fire) state_n = S_LEN_HI;
        S_LEN_HI: if (byte_fire) begin
          if ({1'b0, len_rx} > LEN_MAX) state_n = S_ERR;
          else if (len_rx == '0)        state_n = S_CHK;
          else                          state_n = S_DATA;
        end
        S_DATA:   if (word_valid && last_word) state_n = S_CHK;
        S_CHK:    if (byte_fire) state_n = (rx_data == chk_q) ? S_DONE : S_ERR;
        default:  state_n = state;  // S_DONE / S_ERR hold until load_req
      endcase
    end
  end

  // Datapath and ROM write-port registers. The ROM array itself lives outside
  // this block; a reset or abort only clears these registers.
  // NOTE: the ROM memory is never reset or cleared here -- abort and reset
  // leave earlier words intact; only the write-port registers are reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q     <= '0;
      word_idx  <= '0;
      chk_q     <= '0;
      rom_we    <= 1'b0;
      rom_waddr <= '0;
      rom_wdata <= '0;
      word_cnt  <= '0;
      cpu_rst   <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else if (load_req) begin
      len_q     <= '0;
      word_idx  <= '0;
      chk_q     <= '0;
      rom_we    <= 1'b0;
      rom_waddr <= '0;
      rom_wdata <= '0;
      word_cnt  <= '0;
      cpu_rst   <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      if (byte_fire && state == S_LEN_LO) len_q[7:0]  <= rx_data;
      if (byte_fire && state == S_LEN_HI) len_q[15:8] <= rx_data;
      if (data_fire) chk_q <= chk_q + rx_data;

      rom_we <= word_valid;
      if (word_valid) begin
        rom_waddr <= word_idx[ADDR_W-1:0];
        rom_wdata <= word_out;
        word_idx  <= word_idx + 1'b1;
      end
      // Counts writes actually presented to the ROM, one edge after the strobe.
      if (rom_we) word_cnt <= word_cnt + 1'b1;

      cpu_rst   <= (state == S_DONE);
      load_done <= (state == S_DONE);
      load_err  <= (state == S_ERR);
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// -----------------------------------------------------------------------------
// tb_rom_loader
//   Directed and randomized frames against rom_loader. Expected ROM contents
//   and status come from a frame-level model: words listed per frame, the
//   checksum as a plain byte sum, and completion/error from the frame's
//   length and checksum.
// -----------------------------------------------------------------------------
module tb_rom_loader;

  localparam int DEPTH = 4096;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_req = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_ready;
  logic          rom_we;
  logic [AW-1:0] rom_waddr;
  logic [31:0]   rom_wdata;
  logic          cpu_rst;
  logic          load_done;
  logic          load_err;
  logic [15:0]   word_cnt;

  int n_checks = 0;
  int n_errors = 0;

  rom_loader #(.ROM_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_req  (load_req),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .rom_we    (rom_we),
    .rom_waddr (rom_waddr),
    .rom_wdata (rom_wdata),
    .cpu_rst   (cpu_rst),
    .load_done (load_done),
    .load_err  (load_err),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  // ROM behind the write port, plus pulse statistics.
  logic [31:0] mon_rom [DEPTH];
  logic [31:0] exp_rom [DEPTH];
  int we_count = 0;
  int we_wide  = 0;
  logic prev_we = 1'b0;

  always @(posedge clk) begin
    if (rom_we === 1'b1) begin
      mon_rom[rom_waddr] = rom_wdata;
      we_count++;
      if (prev_we) we_wide++;
    end
    prev_we = (rom_we === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_load_req();
    @(negedge clk);
    load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
  endtask

  // Frame = LEN_LO, LEN_HI, payload LE words, sum-of-payload + chk_add.
  task automatic make_frame(input logic [31:0] words[$], input logic [7:0] chk_add,
                            output logic [7:0] fr[$]);
    logic [7:0] sum;
    int n;
    n = words.size();
    fr.delete();
    sum = 8'h00;
    fr.push_back(8'(n));
    fr.push_back(8'(n >> 8));
    foreach (words[i]) begin
      for (int b = 0; b < 4; b++) begin
        fr.push_back(8'(words[i] >> (8 * b)));
        sum = sum + 8'(words[i] >> (8 * b));
      end
    end
    fr.push_back(sum + chk_add);
  endtask

  // Returns 1 ns after the edge that accepted the last byte, rx_valid low.
  task automatic send_bytes(input logic [7:0] bytes[$], input bit gapped);
    int budget;
    foreach (bytes[i]) begin
      if (gapped) begin
        @(negedge clk);
        rx_valid = 1'b0;
      end
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = bytes[i];
      budget   = 0;
      while (!rx_ready && budget < 50) begin
        @(negedge clk);
        budget++;
      end
      if (!rx_ready) begin
        check("rx_ready timeout", 32'(rx_ready), 32'd1);
        rx_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [31:0] words[$],
                           input bit bad, input bit gapped);
    logic [7:0] fr[$];
    int base, miss, n;
    n = words.size();
    pulse_load_req();
    make_frame(words, bad ? 8'h01 : 8'h00, fr);
    base = we_count;
    send_bytes(fr, gapped);
    foreach (words[i]) exp_rom[i] = words[i];
    check({tag, " rx_ready after CHK"}, 32'(rx_ready), 32'd0);
    @(posedge clk);
    #1;
    check({tag, " load_done"}, 32'(load_done), 32'(!bad));
    check({tag, " load_err"},  32'(load_err),  32'(bad));
    check({tag, " cpu_rst"},   32'(cpu_rst),   32'(!bad));
    check({tag, " word_cnt"},  32'(word_cnt),  32'(n));
    check({tag, " rom_we pulses"}, 32'(we_count - base), 32'(n));
    miss = 0;
    for (int i = 0; i < n; i++) if (mon_rom[i] !== exp_rom[i]) miss++;
    check({tag, " rom words wrong"}, 32'(miss), 32'd0);
  endtask

  initial begin
    logic [31:0] nominal[$];
    logic [31:0] words[$];
    logic [7:0]  fr[$];
    int base;

    nominal = '{32'h0000_0013, 32'h0010_0D13};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("reset rom_we",    32'(rom_we),    32'd0);
    check("reset rom_waddr", 32'(rom_waddr), 32'd0);
    check("reset rom_wdata", rom_wdata,      32'd0);
    check("reset cpu_rst",   32'(cpu_rst),   32'd0);
    check("reset load_done", 32'(load_done), 32'd0);
    check("reset load_err",  32'(load_err),  32'd0);
    check("reset word_cnt",  32'(word_cnt),  32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("rx_ready after reset", 32'(rx_ready), 32'd1);

    // Nominal image (also checks exact first-word contents)
    run_frame("nominal", nominal, 1'b0, 1'b0);
    check("nominal rom[0]", mon_rom[0], 32'h0000_0013);
    check("nominal rom[1]", mon_rom[1], 32'h0010_0D13);
    check("nominal single-cycle we", 32'(we_wide), 32'd0);

    // Bad checksum
    run_frame("badchk", nominal, 1'b1, 1'b0);
    check("badchk rx_ready", 32'(rx_ready), 32'd0);

    // Gapped source
    run_frame("gapped", nominal, 1'b0, 1'b1);

    // Empty image
    words.delete();
    run_frame("empty", words, 1'b0, 1'b0);

    // Length overflow: N = DEPTH + 1, error straight after LEN_HI
    pulse_load_req();
    check("load_req clears done", 32'(load_done), 32'd0);
    check("load_req cpu_rst",     32'(cpu_rst),   32'd0);
    base = we_count;
    fr = '{8'(DEPTH + 1), 8'((DEPTH + 1) >> 8)};
    send_bytes(fr, 1'b0);
    check("ovf rx_ready", 32'(rx_ready), 32'd0);
    @(posedge clk);
    #1;
    check("ovf load_err", 32'(load_err), 32'd1);
    check("ovf cpu_rst",  32'(cpu_rst),  32'd0);
    check("ovf no writes", 32'(we_count - base), 32'd0);

    // Abort after 5 payload bytes, with a byte coincident with load_req
    pulse_load_req();
    words = '{32'hDEAD_BEEF, 32'h1234_5678};
    make_frame(words, 8'h00, fr);
    fr = fr[0:6];  // header + 5 payload bytes
    send_bytes(fr, 1'b0);
    exp_rom[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    check("abort word_cnt before", 32'(word_cnt), 32'd1);
    load_req = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h02;
    @(posedge clk);
    #1;
    load_req = 1'b0;
    rx_valid = 1'b0;
    check("abort word_cnt cleared", 32'(word_cnt), 32'd0);
    check("abort rom[0] partial frame", mon_rom[0], exp_rom[0]);
    base = we_count;
    make_frame(nominal, 8'h00, fr);
    send_bytes(fr, 1'b0);
    @(posedge clk);
    #1;
    check("after abort load_done", 32'(load_done), 32'd1);
    check("after abort writes", 32'(we_count - base), 32'd2);
    check("after abort rom[1]", mon_rom[1], 32'h0010_0D13);

    // Async reset mid-frame, while a write strobe is pending
    pulse_load_req();
    words = '{32'hA5A5_0001, 32'h0BAD_F00D, 32'h0000_0007};
    make_frame(words, 8'h00, fr);
    fr = fr[0:5];  // header + first word
    send_bytes(fr, 1'b0);
    check("pre-rst rom_we", 32'(rom_we), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async rst rom_we",    32'(rom_we),    32'd0);
    check("async rst rom_wdata", rom_wdata,      32'd0);
    check("async rst word_cnt",  32'(word_cnt),  32'd0);
    check("async rst cpu_rst",   32'(cpu_rst),   32'd0);
    check("async rst load_done", 32'(load_done), 32'd0);
    check("async rst load_err",  32'(load_err),  32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_frame("post-rst", nominal, 1'b0, 1'b0);

    // Randomized frames
    for (int t = 0; t < 8; t++) begin
      words.delete();
      for (int i = 0; i < int'($urandom_range(1, 12)); i++) words.push_back($urandom);
      run_frame($sformatf("rand%0d", t), words, ($urandom_range(0, 3) == 0),
                $urandom_range(0, 1) == 1);
    end

    // Largest legal image: N == DEPTH
    words.delete();
    for (int i = 0; i < DEPTH; i++) words.push_back($urandom);
    run_frame("full depth", words, 1'b0, 1'b0);
    check("global single-cycle we", 32'(we_wide), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
